wb_data_initiator: RTL and testbench
====================================

# wb_data_initiator

Wishbone classic initiator for the core's data side: takes one load/store request at a time from a simple valid/ready port, aligns it onto a 32-bit Wishbone bus (byte select, write-data replication), waits for `ack`/`err` or a timeout, and returns a single-cycle response with sign/zero-extended read data. It connects to the data port of the dual-port wishbone RAM (`dwbs_*`) or any other classic Wishbone responder, including responders that assert `ack` in the same cycle as `stb`.

## Interface
- `TIMEOUT`, 256: bus cycles without `ack`/`err` before abort; range 2..65536.
- `clk_i` in 1: clock; every register updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o`.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed_i` in 1: sign-extend load data; ignored for word loads and stores.
- `rsp_valid_o` out 1: one-cycle response pulse.
- `rsp_rdata_o` out 32: extended load data; 0 for stores and errors.
- `rsp_err_o` out 1: bus error, timeout, misaligned or illegal size; valid with `rsp_valid_o`.
- `wbm_addr_o` out 32: `{req_addr[31:2], 2'b00}`.
- `wbm_dat_o` out 32: replicated store data.
- `wbm_sel_o` out 4: byte lanes.
- `wbm_cyc_o` out 1: bus cycle active.
- `wbm_stb_o` out 1: strobe.
- `wbm_we_o` out 1: write enable.
- `wbm_dat_i` in 32: read data.
- `wbm_ack_i` in 1: transfer acknowledge.
- `wbm_err_i` in 1: bus error.

## Operation
- FSM states are IDLE, BUS and RESP. Reset state is IDLE.
- `req_ready_o` is 1 only in IDLE with `rst_i` low.
- IDLE, request accepted, request aligned: latch address, size, signed, we and data; go to BUS.
- IDLE, request accepted, misaligned or size 11: no bus cycle; go to RESP with err=1.
- Misaligned means half with `addr[0]` set, or word with `addr[1:0]` nonzero.
- Byte select: byte gives `4'b0001 << addr[1:0]`; half gives `4'b0011 << addr[1:0]`; word gives `4'b1111`.
- Write data: byte gives `{4{wdata[7:0]}}`; half gives `{2{wdata[15:0]}}`; word is passed unchanged.
- BUS: `wbm_cyc_o = wbm_stb_o = 1`; addr, sel, we and dat stay stable for the whole state.
- BUS: sample `ack`/`err` each cycle.
  - `err` set: go to RESP with err=1. `err` wins if `ack` and `err` are both set.
  - `ack` set: go to RESP with err=0.
  - Neither set and the timeout counter reaches `TIMEOUT-1`: go to RESP with err=1.
  - `ack` arriving in the same cycle as the counter reaching `TIMEOUT-1` counts as success.
- Read data: `wbm_dat_i >> (8*addr[1:0])`, truncated to the request size, then sign- or zero-extended. It is captured in the ack cycle.
- RESP: `rsp_valid_o` = 1 for exactly one cycle, then go to IDLE. No backpressure; the consumer must accept the response.
- Timeout counter is `$clog2(TIMEOUT)` bits wide. It clears on entering BUS and increments once per BUS cycle.

## Timing
- Reset values:
  - `req_ready_o` = 0 while `rst_i` is high.
  - All `wbm_*` outputs = 0.
  - `rsp_valid_o`, `rsp_err_o` = 0.
  - `rsp_rdata_o` = 0.
- Request accepted at edge N: `cyc`/`stb` high during cycle N+1.
- `ack` in cycle N+k (k≥1): `cyc`/`stb` low and `rsp_valid_o` high in cycle N+k+1. With a zero-wait responder, the response lands 2 cycles after acceptance.
- Misaligned request accepted at edge N: `rsp_valid_o` high in cycle N+1; `cyc` never asserted.
- `req_ready_o` returns high the cycle after RESP. Maximum throughput is one transfer per 3 cycles.
- Timeout: `cyc` is held for exactly `TIMEOUT` cycles, then dropped in the RESP cycle.
- `rst_i` asserted mid-transfer: `cyc`/`stb` drop immediately (asynchronously), no response is produced, and the FSM returns to IDLE.
- `wbm_*` outputs are registered; there is no combinational path from `wbm_*_i` to `wbm_*_o`.

## Test plan
- Word store then word load, at 0x100, data 0xDEADBEEF, against the RAM.
  - Store: sel=1111, 2-cycle latency.
  - Load returns 0xDEADBEEF, err=0.
- Byte store 0x80 at 0x103.
  - Store: sel=1000, `wbm_dat_o`=0x80808080.
  - Signed byte load from 0x103 returns 0xFFFFFF80; unsigned returns 0x00000080.
- Half store 0x8001 at 0x102.
  - Store: sel=1100.
  - Signed half load returns 0xFFFF8001.
- Misaligned requests: half at 0x101, word at 0x102, and size=11.
  - Each gives `rsp_valid_o`+`rsp_err_o` one cycle after acceptance; `cyc` stays 0.
- Responder errors:
  - Responder that never acks, `TIMEOUT`=8: `cyc` held 8 cycles, then rsp err=1, rdata=0.
  - Responder asserting `ack` and `err` together: err=1.
- `rst_i` pulsed while in BUS with a stalled responder: `cyc`/`stb` go low in the same cycle, no `rsp_valid_o`, and the next request completes normally.

Source files
------------

// File: rtl/wb_data_initiator.sv
// wb_data_initiator: classic Wishbone data-side initiator.
// Accepts one load/store at a time on a valid/ready port, places it on a
// 32-bit Wishbone bus with byte lanes and replicated store data, waits for
// ack/err or a timeout and returns a one-cycle response with extended data.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   req_*                   request port (valid/ready, addr, wdata, we, size, signed)
//   rsp_*                   response pulse, read data, error
//   wbm_*                   Wishbone classic initiator signals
module wb_data_initiator #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t           r_state, w_state_next;
  logic             r_ready, w_ready_next;
  logic [31:0]      r_wbm_addr, w_wbm_addr_next;
  logic [31:0]      r_wbm_dat, w_wbm_dat_next;
  logic [3:0]       r_wbm_sel, w_wbm_sel_next;
  logic             r_wbm_cyc, w_wbm_cyc_next;
  logic             r_wbm_we, w_wbm_we_next;
  logic [1:0]       r_lane, w_lane_next;
  logic [1:0]       r_size, w_size_next;
  logic             r_signed, w_signed_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_rsp_valid, w_rsp_valid_next;
  logic             r_rsp_err, w_rsp_err_next;
  logic [31:0]      r_rsp_rdata, w_rsp_rdata_next;

  logic             w_bad;
  logic [3:0]       w_req_sel;
  logic [31:0]      w_req_dat;
  logic [31:0]      w_shifted;
  logic [31:0]      w_load_data;

  // Request decode: alignment check, byte lanes and store-data replication
  always_comb begin
    w_bad = (req_size_i == 2'b11) ||
            ((req_size_i == 2'b01) && req_addr_i[0]) ||
            ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
    case (req_size_i)
      2'b00:   w_req_sel = 4'b0001 << req_addr_i[1:0];
      2'b01:   w_req_sel = 4'b0011 << req_addr_i[1:0];
      default: w_req_sel = 4'b1111;
    endcase
    case (req_size_i)
      2'b00:   w_req_dat = {4{req_wdata_i[7:0]}};
      2'b01:   w_req_dat = {2{req_wdata_i[15:0]}};
      default: w_req_dat = req_wdata_i;
    endcase
  end

  // Load data: shift the addressed lane down, then truncate and extend
  always_comb begin
    w_shifted = wbm_dat_i >> {r_lane, 3'b000};
    case (r_size)
      2'b00:   w_load_data = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load_data = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = wbm_dat_i;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_next     = r_state;
    w_wbm_addr_next  = r_wbm_addr;
    w_wbm_dat_next   = r_wbm_dat;
    w_wbm_sel_next   = r_wbm_sel;
    w_wbm_cyc_next   = r_wbm_cyc;
    w_wbm_we_next    = r_wbm_we;
    w_lane_next      = r_lane;
    w_size_next      = r_size;
    w_signed_next    = r_signed;
    w_cnt_next       = r_cnt;
    w_rsp_valid_next = 1'b0;
    w_rsp_err_next   = 1'b0;
    w_rsp_rdata_next = 32'h0;

    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (w_bad) begin
            w_state_next     = S_RESP;
            w_rsp_valid_next = 1'b1;
            w_rsp_err_next   = 1'b1;
          end else begin
            w_state_next    = S_BUS;
            w_wbm_cyc_next  = 1'b1;
            w_wbm_addr_next = {req_addr_i[31:2], 2'b00};
            w_wbm_dat_next  = w_req_dat;
            w_wbm_sel_next  = w_req_sel;
            w_wbm_we_next   = req_we_i;
            w_lane_next     = req_addr_i[1:0];
            w_size_next     = req_size_i;
            w_signed_next   = req_signed_i;
            w_cnt_next      = '0;
          end
        end
      end
      S_BUS: begin
        // err has priority over ack; ack on the last counted cycle still succeeds
        if (wbm_err_i || wbm_ack_i || (r_cnt == CNT_LAST)) begin
          w_state_next     = S_RESP;
          w_rsp_valid_next = 1'b1;
          w_rsp_err_next   = wbm_err_i | ~wbm_ack_i;
          if (wbm_ack_i && !wbm_err_i && !r_wbm_we) begin
            w_rsp_rdata_next = w_load_data;
          end
          w_wbm_cyc_next  = 1'b0;
          w_wbm_addr_next = 32'h0;
          w_wbm_dat_next  = 32'h0;
          w_wbm_sel_next  = 4'h0;
          w_wbm_we_next   = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next    = S_IDLE;
        w_wbm_cyc_next  = 1'b0;
        w_wbm_addr_next = 32'h0;
        w_wbm_dat_next  = 32'h0;
        w_wbm_sel_next  = 4'h0;
        w_wbm_we_next   = 1'b0;
      end
    endcase

    w_ready_next = (w_state_next == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_wbm_addr  <= 32'h0;
      r_wbm_dat   <= 32'h0;
      r_wbm_sel   <= 4'h0;
      r_wbm_cyc   <= 1'b0;
      r_wbm_we    <= 1'b0;
      r_lane      <= 2'b00;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_ready     <= w_ready_next;
      r_wbm_addr  <= w_wbm_addr_next;
      r_wbm_dat   <= w_wbm_dat_next;
      r_wbm_sel   <= w_wbm_sel_next;
      r_wbm_cyc   <= w_wbm_cyc_next;
      r_wbm_we    <= w_wbm_we_next;
      r_lane      <= w_lane_next;
      r_size      <= w_size_next;
      r_signed    <= w_signed_next;
      r_cnt       <= w_cnt_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_err   <= w_rsp_err_next;
      r_rsp_rdata <= w_rsp_rdata_next;
    end
  end

  // Ready is held low for the whole time reset is asserted
  assign req_ready_o = r_ready & ~rst_i;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rsp_rdata;
  assign wbm_addr_o  = r_wbm_addr;
  assign wbm_dat_o   = r_wbm_dat;
  assign wbm_sel_o   = r_wbm_sel;
  assign wbm_cyc_o   = r_wbm_cyc;
  assign wbm_stb_o   = r_wbm_cyc;
  assign wbm_we_o    = r_wbm_we;

endmodule

// File: tb/tb_wb_data_initiator.sv
// Testbench for wb_data_initiator: directed vector table, corner-case
// sequences (timeout, ack+err, reset mid-transfer) and random traffic
// checked against a byte-array reference model.
module tb_wb_data_initiator;

  localparam int unsigned TO = 8;
  localparam int M_ACK = 0, M_NEVER = 1, M_ERR = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_signed_i = 1'b0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] wbm_addr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;

  wb_data_initiator #(.TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- Wishbone responder (RAM with configurable behaviour)
  int          rmode = M_ACK;
  int          rwait = 0;
  logic [31:0] mem [0:255];
  logic        mem_init_done = 1'b0;
  logic [3:0]  bus_cnt;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  assign wbm_dat_i = mem[wbm_addr_o[9:2]];
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o &&
                     ((rmode == M_ERR) || ((rmode == M_ACK) && (bus_cnt == 4'(rwait))));
  assign wbm_err_i = wbm_cyc_o && wbm_stb_o && (rmode == M_ERR);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bus_cnt <= 4'd0;
    else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) bus_cnt <= bus_cnt + 4'd1;
    else bus_cnt <= 4'd0;
  end

  always @(posedge clk_i) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_err_i && wbm_we_o) begin
      for (int l = 0; l < 4; l++)
        if (wbm_sel_o[l]) mem[wbm_addr_o[9:2]][8*l +: 8] <= wbm_dat_o[8*l +: 8];
    end
  end

  // ---------------- Reference model: byte-addressed memory
  logic [7:0] ref_mem [0:1023];

  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [1:0] sz, input logic sg, input int mode, input int waitn,
                       output logic e_err, output logic [31:0] e_rd, output int e_lat,
                       output logic [3:0] e_sel, output logic [31:0] e_dat, output logic e_bad);
    int n, off, base;
    logic [31:0] v;
    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off  = int'(a[1:0]);
    base = int'(a[9:0]) - off;
    e_bad = (sz == 2'd3) || ((off % n) != 0);
    e_sel = 4'h0;
    e_rd  = 32'h0;
    if (!e_bad) for (int i = 0; i < n; i++) e_sel[off + i] = 1'b1;
    if (n == 1)      e_dat = 32'(wd[7:0]) * 32'h01010101;
    else if (n == 2) e_dat = 32'(wd[15:0]) * 32'h00010001;
    else             e_dat = wd;
    if (e_bad) begin
      e_err = 1'b1; e_lat = 1;
    end else if (mode == M_NEVER) begin
      e_err = 1'b1; e_lat = int'(TO) + 1;
    end else if (mode == M_ERR) begin
      e_err = 1'b1; e_lat = 2;
    end else begin
      e_err = 1'b0; e_lat = 2 + waitn;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[base + off + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + off + i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        e_rd = v;
      end
    end
  endtask

  // ---------------- Checking
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endfunction

  // Observations from one transfer
  logic        o_got, o_err, o_we, o_stb_ok, o_cyc_at_rsp, o_extra, o_ready_after, o_ready_at_req;
  logic [31:0] o_rdata, o_dat, o_wbaddr;
  logic [3:0]  o_sel;
  int          o_lat, o_cycs;

  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [1:0] sz, input logic sg, input int mode, input int waitn);
    rmode = mode; rwait = waitn;
    @(negedge clk_i);
    req_addr_i = a; req_wdata_i = wd; req_we_i = we; req_size_i = sz;
    req_signed_i = sg; req_valid_i = 1'b1;
    o_ready_at_req = req_ready_o;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    o_got = 1'b0; o_cycs = 0; o_stb_ok = 1'b1; o_sel = 4'h0; o_dat = 32'h0;
    o_wbaddr = 32'h0; o_we = 1'b0; o_lat = 0; o_err = 1'b0; o_rdata = 32'h0;
    o_cyc_at_rsp = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (wbm_stb_o !== wbm_cyc_o) o_stb_ok = 1'b0;
      if (wbm_cyc_o) begin
        o_cycs++;
        if (o_cycs == 1) begin
          o_sel = wbm_sel_o; o_dat = wbm_dat_o; o_wbaddr = wbm_addr_o; o_we = wbm_we_o;
        end
      end
      if (rsp_valid_o) begin
        o_got = 1'b1; o_lat = k; o_err = rsp_err_o; o_rdata = rsp_rdata_o;
        o_cyc_at_rsp = wbm_cyc_o;
        break;
      end
    end
    @(negedge clk_i);
    o_extra = rsp_valid_o;
    o_ready_after = req_ready_o;
  endtask

  task automatic compare(input string tag, input logic [31:0] a, input logic we,
                         input logic bad, input logic e_err, input logic [31:0] e_rd,
                         input int e_lat, input logic [3:0] e_sel, input logic [31:0] e_dat);
    check({tag, ".ready_req"}, 32'(o_ready_at_req), 32'd1);
    check({tag, ".rsp_seen"}, 32'(o_got), 32'd1);
    if (o_got) begin
      check({tag, ".latency"}, 32'(o_lat), 32'(e_lat));
      check({tag, ".err"}, 32'(o_err), 32'(e_err));
      check({tag, ".rdata"}, o_rdata, e_rd);
      check({tag, ".cyc_cycles"}, 32'(o_cycs), bad ? 32'd0 : 32'(e_lat - 1));
      check({tag, ".cyc_at_rsp"}, 32'(o_cyc_at_rsp), 32'd0);
      check({tag, ".rsp_one_cycle"}, 32'(o_extra), 32'd0);
      check({tag, ".ready_after"}, 32'(o_ready_after), 32'd1);
      check({tag, ".stb_eq_cyc"}, 32'(o_stb_ok), 32'd1);
      if (!bad) begin
        check({tag, ".sel"}, 32'(o_sel), 32'(e_sel));
        check({tag, ".wb_addr"}, o_wbaddr, {a[31:2], 2'b00});
        check({tag, ".we"}, 32'(o_we), 32'(we));
        if (we) check({tag, ".wb_dat"}, o_dat, e_dat);
      end
    end
  endtask

  // ---------------- Directed vector table
  typedef struct {
    int          mode;
    int          waitn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_lat;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int mode, int waitn, logic [31:0] addr, logic [31:0] wdata,
                              logic we, logic [1:0] size, logic sgn, logic e_err,
                              logic [31:0] e_rdata, int e_lat, logic [3:0] e_sel,
                              logic [31:0] e_dat);
    vec_t v;
    v.mode = mode; v.waitn = waitn; v.addr = addr; v.wdata = wdata; v.we = we;
    v.size = size; v.sgn = sgn; v.e_err = e_err; v.e_rdata = e_rdata; v.e_lat = e_lat;
    v.e_sel = e_sel; v.e_dat = e_dat;
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic        m_err, m_bad;
    logic [31:0] m_rd, m_dat, ra, rw;
    logic [3:0]  m_sel;
    int          m_lat, rm, rwt;
    logic [1:0]  rsz;
    logic        rwe, rsg, saw_rsp;

    for (int i = 0; i < 256; i++) begin
      ra = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = ra[8*b +: 8];
    end

    // reset values
    repeat (3) @(negedge clk_i);
    check("rst.ready", 32'(req_ready_o), 32'd0);
    check("rst.cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst.stb", 32'(wbm_stb_o), 32'd0);
    check("rst.we", 32'(wbm_we_o), 32'd0);
    check("rst.sel", 32'(wbm_sel_o), 32'd0);
    check("rst.addr", wbm_addr_o, 32'd0);
    check("rst.dat", wbm_dat_o, 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst.rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst.rsp_rdata", rsp_rdata_o, 32'd0);
    rst_i = 1'b0;
    #1 check("rst.ready_released", 32'(req_ready_o), 32'd1);

    //            mode  wait addr   wdata         we    sz     sg    err   rdata         lat sel   dat
    vecs.push_back(mk(M_ACK,   0, 32'h100, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0,        2, 4'hF, 32'hDEADBEEF));
    vecs.push_back(mk(M_ACK,   0, 32'h100, 32'h0,        1'b0, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF, 2, 4'hF, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h103, 32'h12345680, 1'b1, 2'd0, 1'b0, 1'b0, 32'h0,        2, 4'h8, 32'h80808080));
    vecs.push_back(mk(M_ACK,   0, 32'h103, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0, 32'hFFFFFF80, 2, 4'h8, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h103, 32'h0,        1'b0, 2'd0, 1'b0, 1'b0, 32'h00000080, 2, 4'h8, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h102, 32'hABCD8001, 1'b1, 2'd1, 1'b0, 1'b0, 32'h0,        2, 4'hC, 32'h80018001));
    vecs.push_back(mk(M_ACK,   0, 32'h102, 32'h0,        1'b0, 2'd1, 1'b1, 1'b0, 32'hFFFF8001, 2, 4'hC, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h102, 32'h0,        1'b0, 2'd1, 1'b0, 1'b0, 32'h00008001, 2, 4'hC, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h100, 32'h0,        1'b0, 2'd2, 1'b0, 1'b0, 32'h8001BEEF, 2, 4'hF, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h101, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0, 32'hFFFFFFBE, 2, 4'h2, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h101, 32'h0,        1'b0, 2'd1, 1'b0, 1'b1, 32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h102, 32'h55555555, 1'b1, 2'd2, 1'b0, 1'b1, 32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(M_ACK,   0, 32'h100, 32'h0,        1'b0, 2'd3, 1'b0, 1'b1, 32'h0,        1, 4'h0, 32'h0));
    vecs.push_back(mk(M_ACK,   3, 32'h100, 32'h0,        1'b0, 2'd2, 1'b0, 1'b0, 32'h8001BEEF, 5, 4'hF, 32'h0));
    vecs.push_back(mk(M_ACK,   7, 32'h100, 32'h0,        1'b0, 2'd1, 1'b0, 1'b0, 32'h0000BEEF, 9, 4'h3, 32'h0));
    vecs.push_back(mk(M_NEVER, 0, 32'h100, 32'h0,        1'b0, 2'd2, 1'b0, 1'b1, 32'h0,        9, 4'hF, 32'h0));
    vecs.push_back(mk(M_ERR,   0, 32'h100, 32'h0,        1'b0, 2'd2, 1'b0, 1'b1, 32'h0,        2, 4'hF, 32'h0));
    vecs.push_back(mk(M_ERR,   0, 32'h100, 32'h11111111, 1'b1, 2'd2, 1'b0, 1'b1, 32'h0,        2, 4'hF, 32'h11111111));
    vecs.push_back(mk(M_ACK,   0, 32'h100, 32'h0,        1'b0, 2'd2, 1'b0, 1'b0, 32'h8001BEEF, 2, 4'hF, 32'h0));
    vecs.push_back(mk(M_ACK,   1, 32'h102, 32'h0,        1'b0, 2'd0, 1'b1, 1'b0, 32'h00000001, 3, 4'h4, 32'h0));

    foreach (vecs[i]) begin
      // keep the reference memory in step with the directed traffic
      model(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size, vecs[i].sgn,
            vecs[i].mode, vecs[i].waitn, m_err, m_rd, m_lat, m_sel, m_dat, m_bad);
      xfer(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size, vecs[i].sgn,
           vecs[i].mode, vecs[i].waitn);
      compare($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, m_bad, vecs[i].e_err,
              vecs[i].e_rdata, vecs[i].e_lat, vecs[i].e_sel, vecs[i].e_dat);
    end

    // reset pulsed mid-transfer with a stalled responder
    rmode = M_NEVER;
    @(negedge clk_i);
    req_addr_i = 32'h104; req_we_i = 1'b0; req_size_i = 2'd2; req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rstmid.cyc_before", 32'(wbm_cyc_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rstmid.cyc", 32'(wbm_cyc_o), 32'd0);
    check("rstmid.stb", 32'(wbm_stb_o), 32'd0);
    check("rstmid.ready", 32'(req_ready_o), 32'd0);
    saw_rsp = rsp_valid_o;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o || wbm_cyc_o) saw_rsp = 1'b1;
    end
    check("rstmid.no_rsp", 32'(saw_rsp), 32'd0);
    check("rstmid.ready_after", 32'(req_ready_o), 32'd1);
    model(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, M_ACK, 0, m_err, m_rd, m_lat, m_sel, m_dat, m_bad);
    xfer(32'h100, 32'h0, 1'b0, 2'd2, 1'b0, M_ACK, 0);
    compare("rstmid.next", 32'h100, 1'b0, m_bad, m_err, m_rd, m_lat, m_sel, m_dat);

    // random traffic against the reference model
    for (int t = 0; t < 200; t++) begin
      rm  = int'($urandom_range(0, 9));
      rwt = int'($urandom_range(0, 3));
      if (rm == 0) rm = M_NEVER;
      else if (rm == 1) rm = M_ERR;
      else rm = M_ACK;
      rsz = 2'($urandom_range(0, 3));
      rwe = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      rw  = $urandom();
      ra  = $urandom();
      ra  = (ra & 32'hFFF0_03FF);
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) ra[0] = 1'b0;
        else if (rsz == 2'd2) ra[1:0] = 2'b00;
      end
      model(ra, rw, rwe, rsz, rsg, rm, rwt, m_err, m_rd, m_lat, m_sel, m_dat, m_bad);
      xfer(ra, rw, rwe, rsz, rsg, rm, rwt);
      compare($sformatf("rnd%0d", t), ra, rwe, m_bad, m_err, m_rd, m_lat, m_sel, m_dat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
